// File: rtl/framer_pkg.sv
// Shared types and constants for the FIFO packet framer.
// FRAMER_CHECKSUM_EN adds the trailing checksum state.
package framer_pkg;

    localparam int          FRAMER_DATA_W = 8;
    localparam logic [7:0]  FRAMER_SOF    = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOF,
        S_LEN,
        S_RD_REQ,
        S_RD_CAP,
`ifdef FRAMER_CHECKSUM_EN
        S_PAYLOAD,
        S_CHK
`else
        S_PAYLOAD
`endif
    } state_e;

endpackage

// File: rtl/fifo_pkt_framer.sv
// Frames FIFO bytes as SOF, LEN, payload[, checksum] packets.
// FRAMER_CHECKSUM_EN (undefined by default) appends the checksum byte.
module fifo_pkt_framer
    import framer_pkg::*;
#(
    parameter int         DATA_W  = FRAMER_DATA_W,
    parameter int         PKT_LEN = 4,
    parameter logic [7:0] SOF     = FRAMER_SOF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_rd,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic [15:0]       pkt_cnt
);

    localparam logic [DATA_W-1:0] LEN_B    = DATA_W'(PKT_LEN);
    localparam logic [7:0]        LAST_IDX = 8'(PKT_LEN - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [15:0]       pkt_q, pkt_d;
`ifdef FRAMER_CHECKSUM_EN
    logic [DATA_W-1:0] acc_q, acc_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            pkt_q   <= '0;
`ifdef FRAMER_CHECKSUM_EN
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            pkt_q   <= pkt_d;
`ifdef FRAMER_CHECKSUM_EN
            acc_q   <= acc_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        pkt_d     = pkt_q;
`ifdef FRAMER_CHECKSUM_EN
        acc_d     = acc_q;
`endif
        fifo_rd   = 1'b0;
        out_data  = '0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (!fifo_empty) begin
                    state_d = S_SOF;
                    cnt_d   = '0;
`ifdef FRAMER_CHECKSUM_EN
                    acc_d   = '0;
`endif
                end
            end
            S_SOF: begin
                out_valid = 1'b1;
                out_data  = SOF;
                if (out_ready) state_d = S_LEN;
            end
            S_LEN: begin
                out_valid = 1'b1;
                out_data  = LEN_B;
                if (out_ready) begin
`ifdef FRAMER_CHECKSUM_EN
                    acc_d   = LEN_B;
`endif
                    state_d = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                if (!fifo_empty) begin
                    fifo_rd = 1'b1;
                    state_d = S_RD_CAP;
                end
            end
            S_RD_CAP: begin
                data_d  = fifo_dout;
`ifdef FRAMER_CHECKSUM_EN
                acc_d   = acc_q + fifo_dout;
`endif
                state_d = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                out_valid = 1'b1;
                out_data  = data_q;
`ifndef FRAMER_CHECKSUM_EN
                out_last  = (cnt_q == LAST_IDX);
`endif
                if (out_ready) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == LAST_IDX) begin
`ifdef FRAMER_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        pkt_d   = pkt_q + 16'd1;
                        state_d = S_IDLE;
`endif
                    end else begin
                        state_d = S_RD_REQ;
                    end
                end
            end
`ifdef FRAMER_CHECKSUM_EN
            S_CHK: begin
                out_valid = 1'b1;
                out_data  = acc_q;
                out_last  = 1'b1;
                if (out_ready) begin
                    pkt_d   = pkt_q + 16'd1;
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign pkt_cnt = pkt_q;

endmodule

// File: tb/tb_fifo_pkt_framer.sv
// Randomised bench for fifo_pkt_framer with a packet-level reference model.
// Follows FRAMER_CHECKSUM_EN to pick the expected framing.
module tb_fifo_pkt_framer;

`ifdef FRAMER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  fifo_dout = 8'h00;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last;
    logic        busy;
    logic [15:0] pkt_cnt;

    always #5 clk = ~clk;

    fifo_pkt_framer #(
        .DATA_W (8),
        .PKT_LEN(N),
        .SOF    (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_dout (fifo_dout),
        .fifo_empty(fifo_empty),
        .fifo_rd   (fifo_rd),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .pkt_cnt   (pkt_cnt)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Upstream FIFO: data appears on fifo_dout the cycle after fifo_rd.
    logic [7:0] fifo_q[$];
    logic [7:0] pend_q[$];
    logic [7:0] ref_q[$];

    task automatic push(input logic [7:0] b);
        pend_q.push_back(b);
        ref_q.push_back(b);
    endtask

    always @(posedge clk) begin
        if (fifo_rd && fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
        while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
        fifo_empty <= (fifo_q.size() == 0);
    end

    int rdy_mode = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = ($urandom_range(3) != 0);
        endcase
    end

    // Reference model: position within the packet drives the expected byte.
    int          pos = 0;
    int          pops = 0;
    int          used = 0;
    int          tot_pops = 0;
    logic [7:0]  macc = 8'h00;
    logic [15:0] mdl_cnt = 16'h0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_d = 8'h00;
    logic        prev_l = 1'b0;
    logic [7:0]  log_d[$];
    bit          log_l[$];

    always @(negedge clk) begin
        logic [7:0] eb;
        logic       el;
        if (rst) begin
            if (fifo_rd) pops++;
            for (int i = used; i < pops; i++)
                if (ref_q.size() > 0) void'(ref_q.pop_front());
            pos = 0; pops = 0; used = 0; macc = 8'h00;
            mdl_cnt = 16'h0; prev_stall = 1'b0;
        end else begin
            chk("pkt_cnt", pkt_cnt, mdl_cnt);
            if (fifo_rd) begin
                chk("rd_while_empty", fifo_empty, 1'b0);
                pops++;
                tot_pops++;
            end
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_data", out_data, prev_d);
                chk("hold_last", out_last, prev_l);
            end
            chk("busy", busy, (pos != 0) ? 1'b1 : out_valid);
            if (out_valid && out_ready) begin
                eb = 8'h00;
                el = 1'b0;
                if (pos == 0) begin
                    eb = 8'hA5;
                end else if (pos == 1) begin
                    eb = 8'(N);
                    macc = 8'(N);
                end else if (pos <= N + 1) begin
                    if (ref_q.size() == 0) begin
                        chk("ref_underflow", 32'd0, 32'd1);
                    end else begin
                        eb = ref_q.pop_front();
                        used++;
                        macc = macc + eb;
                    end
                    el = !CHK_EN && (pos == N + 1);
                end else begin
                    eb = macc;
                    el = 1'b1;
                end
                chk($sformatf("data_pos%0d", pos), out_data, eb);
                chk($sformatf("last_pos%0d", pos), out_last, el);
                log_d.push_back(out_data);
                log_l.push_back(out_last);
                if (el) begin
                    chk("pops_per_pkt", pops, N);
                    mdl_cnt = mdl_cnt + 16'd1;
                    pos = 0; pops = 0; used = 0;
                end else begin
                    pos++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_d = out_data;
            prev_l = out_last;
        end
    end

    task automatic clear_log();
        log_d.delete();
        log_l.delete();
    endtask

    task automatic wait_cnt(input string nm, input logic [15:0] target,
                            input int budget);
        int k = 0;
        while (pkt_cnt !== target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(nm, pkt_cnt, target);
    endtask

    task automatic check_log(input string nm, input logic [7:0] e[7],
                             input int n);
        chk({nm, "_len"}, log_d.size(), n);
        for (int i = 0; i < n && i < log_d.size(); i++) begin
            chk($sformatf("%s_b%0d", nm, i), log_d[i], e[i]);
            chk($sformatf("%s_l%0d", nm, i), log_l[i], (i == n - 1));
        end
    endtask

    logic [7:0] e18[7] = '{8'hA5, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAE};
    logic [7:0] e22[7] = '{8'hA5, 8'h04, 8'hFF, 8'h01, 8'h80, 8'h7F, 8'h03};
    int         nb = CHK_EN ? 7 : 6;
    int         exp_pk = 0;

    initial begin
        int sz;
        int need;
        int k;
        int r0;
        int lasts;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, 8'h00);
        chk("rst_last", out_last, 1'b0);
        chk("rst_rd", fifo_rd, 1'b0);
        chk("rst_cnt", pkt_cnt, 16'h0);

        clear_log();
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        wait_cnt("basic_done", 16'd1, 200);
        check_log("basic", e18, nb);

        rdy_mode = 1;
        clear_log();
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        wait_cnt("toggle_done", 16'd2, 400);
        check_log("toggle", e18, nb);
        rdy_mode = 0;

        clear_log();
        push(8'h11); push(8'h22);
        repeat (20) @(negedge clk);
        chk("stall_busy", busy, 1'b1);
        chk("stall_valid", out_valid, 1'b0);
        chk("stall_cnt", pkt_cnt, 16'd2);
        push(8'h33); push(8'h44);
        wait_cnt("stall_done", 16'd3, 200);
        check_log("stall", e18, nb);

        clear_log();
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        k = 0;
        while (!(out_valid && out_ready && out_data == 8'h22) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("see_22", out_data, 8'h22);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_data", out_data, 8'h00);
        chk("mid_rst_last", out_last, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_cnt", pkt_cnt, 16'h0);
        sz = fifo_q.size() + pend_q.size();
        need = (sz == 0) ? 4 : (4 - sz % 4) % 4;
        for (int i = 0; i < need; i++) push(8'($urandom));
        exp_pk = (sz + need) / 4;
        wait_cnt("fresh_done", 16'(exp_pk), 400);

        clear_log();
        push(8'hFF); push(8'h01); push(8'h80); push(8'h7F);
        exp_pk++;
        wait_cnt("edge_done", 16'(exp_pk), 200);
        check_log("edge", e22, nb);

        rdy_mode = 2;
        clear_log();
        r0 = tot_pops;
        for (int i = 0; i < 32; i++) push(8'($urandom));
        exp_pk += 8;
        wait_cnt("b2b_done", 16'(exp_pk), 2000);
        chk("b2b_pops", tot_pops - r0, 32);
        chk("b2b_bytes", log_d.size(), 8 * (N + 2 + int'(CHK_EN)));
        lasts = 0;
        foreach (log_l[i]) if (log_l[i]) lasts++;
        chk("b2b_lasts", lasts, 8);
        rdy_mode = 0;

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
